// File: rtl/match_ctrl.sv
// match_ctrl -- score keeper and sequencer for a two-player reaction game.
//
// A match starts on a start-key rising edge. During PLAY a player scores
// by pressing their key while the light on their side of the playfield is
// lit. After each point the playfield is re-centred for HOLD_CYC clocks.
// The first player to reach WIN_SCORE ends the match. The scores and the
// winner are then held until the next start edge.
//
// Ports
//   clk        : clock. All state changes on its rising edge.
//   reset      : asynchronous, active-low reset.
//   start      : start key level. Only its rising edge acts.
//   L, R       : left and right player key levels.
//   LL, RL     : leftmost and rightmost playfield light is on.
//   LS, RS     : left and right scores (0..WIN_SCORE).
//   resetLight : holds the playfield in its centred start position.
//   play_en    : the playfield may respond to keys.
//   winner     : 00 none, 01 left, 10 right.
module match_ctrl #(
  parameter int WIN_SCORE = 7,   // 1..7
  parameter int HOLD_CYC  = 4    // 1..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       L,
  input  logic       R,
  input  logic       LL,
  input  logic       RL,
  output logic [2:0] LS,
  output logic [2:0] RS,
  output logic       resetLight,
  output logic       play_en,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    POINT = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [2:0] WIN       = 3'(WIN_SCORE);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC - 1);

  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_LEFT  = 2'b01;
  localparam logic [1:0] WINNER_RIGHT = 2'b10;

  state_t     state, state_nxt;
  logic [7:0] hold, hold_nxt;
  logic [2:0] ls_nxt, rs_nxt;
  logic [1:0] winner_nxt;

  // Delayed copies of the key levels. They are updated in every state,
  // including POINT. A key that is held through POINT therefore gives no
  // rising edge when PLAY resumes.
  logic start_q, l_q, r_q;
  logic rise_start, rise_l, rise_r;
  logic pt_l, pt_r;

  assign rise_start = start & ~start_q;
  assign rise_l     = L & ~l_q;
  assign rise_r     = R & ~r_q;

  // A point needs a clean press from exactly one player. If both keys rise
  // in the same cycle, neither player scores, whatever the lights show.
  assign pt_l = LL & rise_l & ~rise_r;
  assign pt_r = RL & rise_r & ~rise_l;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b0;
      l_q     <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      start_q <= start;
      l_q     <= L;
      r_q     <= R;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      hold   <= 8'd0;
      LS     <= 3'd0;
      RS     <= 3'd0;
      winner <= WINNER_NONE;
    end else begin
      state  <= state_nxt;
      hold   <= hold_nxt;
      LS     <= ls_nxt;
      RS     <= rs_nxt;
      winner <= winner_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold;
    ls_nxt     = LS;
    rs_nxt     = RS;
    winner_nxt = winner;

    unique case (state)
      IDLE: begin
        if (rise_start) state_nxt = PLAY;
      end

      PLAY: begin
        // In PLAY both scores are always below WIN. The score guard stops a
        // score from going past WIN_SCORE if that is ever not true.
        if (pt_l && LS != WIN) begin
          ls_nxt    = LS + 3'd1;
          hold_nxt  = HOLD_LOAD;
          state_nxt = POINT;
        end else if (pt_r && RS != WIN) begin
          rs_nxt    = RS + 3'd1;
          hold_nxt  = HOLD_LOAD;
          state_nxt = POINT;
        end
      end

      POINT: begin
        // Loaded with HOLD_CYC-1, so POINT lasts exactly HOLD_CYC clocks.
        if (hold == 8'd0) begin
          if (LS == WIN) begin
            winner_nxt = WINNER_LEFT;
            state_nxt  = OVER;
          end else if (RS == WIN) begin
            winner_nxt = WINNER_RIGHT;
            state_nxt  = OVER;
          end else begin
            state_nxt  = PLAY;
          end
        end else begin
          hold_nxt = hold - 8'd1;
        end
      end

      OVER: begin
        if (rise_start) begin
          ls_nxt     = 3'd0;
          rs_nxt     = 3'd0;
          winner_nxt = WINNER_NONE;
          state_nxt  = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // These outputs come from the state alone. Reset forces IDLE at once,
  // so they also take their reset values without a clock.
  assign resetLight = (state == IDLE) || (state == POINT);
  assign play_en    = (state == PLAY);

endmodule
